// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Arbitrates two requesters onto one shared, purely combinational ALU.
//   One operation is in flight at a time. Each operation is accepted in
//   IDLE, executed for one cycle in EXEC, and then held in RESP until the
//   owning requester takes the result.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no operation in flight; arbitrate and accept one request
//   EXEC  | captured operands drive the ALU; result registered at edge
//   RESP  | result presented to the owner until it asserts rsp ready
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN_valid/ready            request handshake, requester N
//   reqN_a, reqN_b, reqN_op     operands and ALU control of requester N
//   rspN_valid/ready            response handshake, requester N
//   rspN_res, rspN_flags        result and {err, overflow, zero, co}
//   alu_a, alu_b, alu_ctr       drive to the shared ALU (zero outside EXEC)
//   alu_res, alu_co,
//   alu_zero, alu_overflow      combinational ALU outputs
//   busy                        high whenever an operation is in flight
//
// Parameter
//   CHECK_OP  1: opcodes 011/100/101 are rejected with err set
//             0: every opcode is passed to the ALU unchanged

module alu_arbiter #(
  parameter int CHECK_OP = 1
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_op,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_op,

  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_res,
  output logic [3:0]  rsp0_flags,

  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_res,
  output logic [3:0]  rsp1_flags,

  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctr,
  input  logic [31:0] alu_res,
  input  logic        alu_co,
  input  logic        alu_zero,
  input  logic        alu_overflow,

  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        rr;

  logic [31:0] cap_a;
  logic [31:0] cap_b;
  logic [2:0]  cap_op;
  logic        cap_owner;

  logic [31:0] res_q;
  logic [3:0]  flags_q;

  logic        grant0;
  logic        grant1;
  logic        accept;
  logic        rsp_done;
  logic        op_illegal;

  function automatic logic is_reserved(input logic [2:0] op);
    return (op == 3'b011) || (op == 3'b100) || (op == 3'b101);
  endfunction

  assign op_illegal = (CHECK_OP != 0) && is_reserved(cap_op);

  // Arbitration. Ready is gated by rst_n so nothing appears granted while
  // the block is held in reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if ((state == IDLE) && rst_n) begin
      if (req0_valid && req1_valid) begin
        grant0 = ~rr;
        grant1 = rr;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // A grant is only ever given to a valid requester, so a grant is a handshake.
  assign accept   = grant0 | grant1;
  assign rsp_done = (state == RESP) && (cap_owner ? rsp1_ready : rsp0_ready);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (rsp_done) rr <= ~cap_owner;
    end
  end

  // Requester fields are sampled only on the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_a     <= '0;
      cap_b     <= '0;
      cap_op    <= 3'b000;
      cap_owner <= 1'b0;
    end else if (accept) begin
      cap_a     <= grant1 ? req1_a  : req0_a;
      cap_b     <= grant1 ? req1_b  : req0_b;
      cap_op    <= grant1 ? req1_op : req0_op;
      cap_owner <= grant1;
    end
  end

  // Result capture at the end of EXEC. A rejected opcode still spends its
  // EXEC cycle so the latency stays the same for every operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      flags_q <= 4'b0000;
    end else if (state == EXEC) begin
      if (op_illegal) begin
        res_q   <= '0;
        flags_q <= 4'b1000;
      end else begin
        res_q   <= alu_res;
        flags_q <= {1'b0, alu_overflow, alu_zero, alu_co};
      end
    end
  end

  // The ALU sees the captured operation only during EXEC; otherwise it is
  // parked at zero so it does not toggle with requester traffic.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_ctr = 3'b000;
    if (state == EXEC) begin
      alu_a   = cap_a;
      alu_b   = cap_b;
      alu_ctr = op_illegal ? 3'b000 : cap_op;
    end
  end

  assign rsp0_valid = (state == RESP) && !cap_owner;
  assign rsp1_valid = (state == RESP) &&  cap_owner;

  assign rsp0_res   = res_q;
  assign rsp0_flags = flags_q;
  assign rsp1_res   = res_q;
  assign rsp1_flags = flags_q;

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_res, rsp1_res;
  logic [3:0]  rsp0_flags, rsp1_flags;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [2:0]  alu_ctr;
  logic        alu_co, alu_zero, alu_overflow;
  logic        busy;
  logic [35:0] alu_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.CHECK_OP(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_res(rsp0_res), .rsp0_flags(rsp0_flags),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_res(rsp1_res), .rsp1_flags(rsp1_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr),
    .alu_res(alu_res), .alu_co(alu_co), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow),
    .busy(busy)
  );

  // Behaviour of the shared ALU: returns {0, overflow, zero, co, res}.
  function automatic logic [35:0] alu_fn(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic        co;
    logic        ov;
    s = '0; r = '0; co = 1'b0; ov = 1'b0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[31:0];
        co = s[32];
        ov = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'b110: begin
        s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r  = s[31:0];
        co = s[32];
        ov = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'b111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = 32'hDEAD_BEEF;
    endcase
    return {1'b0, ov, (r == 32'd0), co, r};
  endfunction

  function automatic logic is_rsvd(input logic [2:0] op);
    return op inside {3'b011, 3'b100, 3'b101};
  endfunction

  assign alu_out      = alu_fn(alu_ctr, alu_a, alu_b);
  assign alu_res      = alu_out[31:0];
  assign alu_co       = alu_out[32];
  assign alu_zero     = alu_out[33];
  assign alu_overflow = alu_out[34];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------
  // Reference model: one operation in flight, described as "accepted on
  // some edge, result owed from the second cycle onward until taken".
  // ---------------------------------------------------------------------
  logic        m_busy, m_rr, m_owner;
  int          m_cycles;
  logic [31:0] m_a, m_b;
  logic [2:0]  m_op;
  logic [35:0] m_exp;
  logic [1:0]  e_rdy, e_rsp;
  logic        e_busy, has, win;
  logic [31:0] e_aa, e_ab;
  logic [2:0]  e_ctr;

  initial begin : compare
    m_busy = 1'b0; m_rr = 1'b0; m_owner = 1'b0; m_cycles = 0;
    m_a = '0; m_b = '0; m_op = '0; m_exp = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 1'b0;
        m_rr   = 1'b0;
      end
      e_rdy = 2'b00; e_rsp = 2'b00; e_aa = '0; e_ab = '0; e_ctr = 3'b000;
      has = req0_valid | req1_valid;
      win = (req0_valid && req1_valid) ? m_rr : !req0_valid;
      if (rst_n && !m_busy && has) e_rdy[win] = 1'b1;
      e_busy = m_busy;
      if (m_busy && m_cycles == 0) begin
        e_aa  = m_a;
        e_ab  = m_b;
        e_ctr = is_rsvd(m_op) ? 3'b000 : m_op;
      end
      if (m_busy && m_cycles >= 1) e_rsp[m_owner] = 1'b1;

      chk("ready",     {30'd0, req1_ready, req0_ready}, {30'd0, e_rdy});
      chk("rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, {30'd0, e_rsp});
      chk("busy",      {31'd0, busy}, {31'd0, e_busy});
      chk("alu_a",     alu_a, e_aa);
      chk("alu_b",     alu_b, e_ab);
      chk("alu_ctr",   {29'd0, alu_ctr}, {29'd0, e_ctr});
      if (e_rsp[0]) begin
        chk("rsp0_res",   rsp0_res, m_exp[31:0]);
        chk("rsp0_flags", {28'd0, rsp0_flags}, {28'd0, m_exp[35:32]});
      end
      if (e_rsp[1]) begin
        chk("rsp1_res",   rsp1_res, m_exp[31:0]);
        chk("rsp1_flags", {28'd0, rsp1_flags}, {28'd0, m_exp[35:32]});
      end

      if (rst_n) begin
        if (!m_busy) begin
          if (has) begin
            m_busy   = 1'b1;
            m_cycles = 0;
            m_owner  = win;
            m_a      = win ? req1_a  : req0_a;
            m_b      = win ? req1_b  : req0_b;
            m_op     = win ? req1_op : req0_op;
            m_exp    = is_rsvd(m_op) ? {4'b1000, 32'd0} : alu_fn(m_op, m_a, m_b);
          end
        end else if (m_cycles == 0) begin
          m_cycles = 1;
        end else if (m_owner ? rsp1_ready : rsp0_ready) begin
          m_busy = 1'b0;
          m_rr   = !m_owner;
        end
      end
    end
  end

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0:       v = 32'($urandom_range(0, 15));
      1:       v = ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      2:       v = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'd1;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  int g_cyc[$];
  int g_id[$];

  initial begin : stim
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 32'd1; req0_b = 32'd2; req0_op = 3'b010;
    req1_a = 32'd3; req1_b = 32'd4; req1_op = 3'b010;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Held in reset with both requests valid.
    tick(); tick();
    #1;
    chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("rst_alu_ctr",    {29'd0, alu_ctr}, 32'd0);
    chk("rst_alu_a",      alu_a, 32'd0);
    chk("rst_busy",       {31'd0, busy}, 32'd0);
    chk("rst_rsp0_res",   rsp0_res, 32'd0);
    chk("rst_rsp0_flags", {28'd0, rsp0_flags}, 32'd0);

    tick();
    rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;

    // req0 ADD 5 + 7.
    tick();
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = 3'b010; rsp0_ready = 1'b1;
    #1 chk("add_ready", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    #1 chk("add_exec_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("add_exec_alu_a", alu_a, 32'd5);
    tick();
    #1 chk("add_rsp_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("add_res",   rsp0_res, 32'd12);
    chk("add_flags", {28'd0, rsp0_flags}, 32'h0);
    tick();
    #1 chk("add_valid_one_cycle", {31'd0, rsp0_valid}, 32'd0);

    // req1 SUB 9 - 9.
    req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd9; req1_op = 3'b110; rsp1_ready = 1'b1;
    #1 chk("sub_ready", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    tick();
    #1 chk("sub_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    chk("sub_res",   rsp1_res, 32'd0);
    chk("sub_flags", {28'd0, rsp1_flags}, 32'h3);
    chk("sub_rsp0_quiet", {31'd0, rsp0_valid}, 32'd0);
    tick();

    // Both requesters continuously valid: grants alternate 0,1,0,1 every 3 cycles.
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = 3'b001;
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_op = 3'b000;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (req0_ready) begin g_cyc.push_back(c); g_id.push_back(0); end
      if (req1_ready) begin g_cyc.push_back(c); g_id.push_back(1); end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("grant_count", g_id.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < g_id.size()) begin
        chk("grant_id",  g_id[i],  i % 2);
        chk("grant_cyc", g_cyc[i], 3 * i);
      end
    end

    // Response back-pressure for 5 cycles; req1 waits meanwhile.
    tick();
    req0_valid = 1'b1; req0_a = 32'h7FFF_FFFF; req0_b = 32'd1; req0_op = 3'b010;
    rsp0_ready = 1'b0;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'hF0; req1_b = 32'h3C; req1_op = 3'b000;
    tick();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_valid", {31'd0, rsp0_valid}, 32'd1);
      chk("stall_res",   rsp0_res, 32'h8000_0000);
      chk("stall_flags", {28'd0, rsp0_flags}, 32'h4);
      chk("stall_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      chk("stall_busy",  {31'd0, busy}, 32'd1);
      tick();
    end
    rsp0_ready = 1'b1;
    #1 chk("no_accept_on_rsp", {31'd0, req1_ready}, 32'd0);
    chk("stall_done_valid", {31'd0, rsp0_valid}, 32'd1);
    tick();
    #1 chk("stall_idle", {31'd0, busy}, 32'd0);
    chk("idle_req1_ready", {31'd0, req1_ready}, 32'd1);
    req1_valid = 1'b0;
    tick();
    #1 chk("dropped_not_granted", {31'd0, busy}, 32'd0);

    // Rejected opcode, then a reset in the middle of the next EXEC.
    req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd5; req0_op = 3'b011;
    tick();
    req0_valid = 1'b0;
    #1 chk("rsvd_alu_ctr", {29'd0, alu_ctr}, 32'd0);
    chk("rsvd_alu_a", alu_a, 32'd3);
    tick();
    #1 chk("rsvd_res",   rsp0_res, 32'd0);
    chk("rsvd_flags", {28'd0, rsp0_flags}, 32'h8);
    tick();
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 3'b010;
    tick();
    req0_valid = 1'b0;
    #1 chk("exec_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1 chk("rst_exec_busy", {31'd0, busy}, 32'd0);
    chk("rst_exec_alu_a", alu_a, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1 chk("post_rst_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      tick();
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1 chk("post_rst_arb", {30'd0, req1_ready, req0_ready}, 32'd1);

    // Random traffic, occasional reset pulses; the model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst_n      = ($urandom_range(0, 299) != 0);
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      req0_op    = 3'($urandom_range(0, 7));
      req1_op    = 3'($urandom_range(0, 7));
      req0_a     = rand_operand();
      req0_b     = ($urandom_range(0, 4) == 0) ? req0_a : rand_operand();
      req1_a     = rand_operand();
      req1_b     = ($urandom_range(0, 4) == 0) ? req1_a : rand_operand();
      rsp0_ready = ($urandom_range(0, 2) != 0);
      rsp1_ready = ($urandom_range(0, 2) != 0);
    end

    tick();
    rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (!busy) break;
      tick();
    end
    chk("drain_timeout", {31'd0, busy}, 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter CHECK_OP, default 1, meaning: 1 = opcodes 3'b011/3'b100/3'b101 are rejected with err; 0 = they are passed to the ALU unchanged.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1  requester N has an operation pending.
REQ-005 req0_ready / req1_ready  output  1  operation of requester N is accepted this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  32  operands.
REQ-007 req0_op / req1_op  input  3  ALU control: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
REQ-008 rsp0_valid / rsp1_valid  output  1  result for requester N available.
REQ-009 rsp0_ready / rsp1_ready  input  1  requester N consumes the result.
REQ-010 rsp0_res / rsp1_res  output  32  result.
REQ-011 rsp0_flags / rsp1_flags  output  4  {err, overflow, zero, co}.
REQ-012 alu_a, alu_b  output  32  operands driven to the shared ALU.
REQ-013 alu_ctr  output  3  control driven to the shared ALU.
REQ-014 alu_res  input  32;  alu_co, alu_zero, alu_overflow  input  1 each  ALU outputs, combinational from alu_a/alu_b/alu_ctr.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, EXEC, RESP.
REQ-017 In IDLE, if exactly one req valid, that requester SHALL win; if both, the requester named by the round-robin pointer rr SHALL win.
REQ-018 In IDLE, reqN_ready SHALL be high combinationally for the winner only; all other cycles, both ready outputs SHALL be 0.
REQ-019 On handshake (valid & ready at a rising edge): a, b, op and owner ID SHALL be captured into internal registers; state goes to EXEC.
REQ-020 In EXEC, alu_a/alu_b/alu_ctr SHALL drive the captured values; at the EXEC edge, alu_res and flags SHALL be registered; state goes to RESP.
REQ-021 Outside EXEC, alu_a = alu_b = 0 and alu_ctr = 3'b000.
REQ-022 In RESP, rspN_valid SHALL be high for the owner only, with res/flags held stable until rspN_ready is sampled high; state then goes to IDLE and rr = other requester.
REQ-023 Latency: handshake at edge N -> rsp valid after edge N+1, seen from edge N+2 sampling; minimum 3 cycles per operation.
REQ-024 If CHECK_OP=1 and op is 011/100/101: EXEC still occupies one cycle, ALU driven with ctr 000; result SHALL be res=0, flags=4'b1000.
REQ-025 Flags SHALL be copied from ALU outputs unmodified (err=0) for legal ops; no width extension or arithmetic in this block.
REQ-026 A requester SHALL be allowed to drop valid before ready with no side effect; a dropped request is never granted.
REQ-027 A new request SHALL NOT be accepted in the same cycle a response handshakes (IDLE entered first).
REQ-028 Requester fields are sampled only at handshake; later changes SHALL NOT affect an in-flight operation.

Reset
REQ-029 On rst_n low, asynchronously: state=IDLE, rr=0, all captured registers=0, rsp*_valid=0, rsp*_res=0, rsp*_flags=0, busy=0.
REQ-030 Reset mid-EXEC or mid-RESP SHALL discard the operation with no response issued after release.
REQ-031 First cycle after release SHALL be IDLE with normal arbitration.

Verification
REQ-032 Reset: hold rst_n=0 with both req valid -> req*_ready=0, rsp*_valid=0, alu_ctr=000, alu_a=0, busy=0.
REQ-033 req0 ADD a=5 b=7 op=010, rsp0_ready=1 -> rsp0_res=12, flags=0000, rsp0_valid for one cycle 2 edges after handshake.
REQ-034 req1 SUB a=9 b=9 op=110 -> rsp1_res=0, flags=0011 (zero=1, co=1); rsp0_valid stays 0.
REQ-035 Both valid continuously after reset -> grant order 0,1,0,1; each grant 3 cycles apart.
REQ-036 rsp0_ready=0 for 5 cycles in RESP -> rsp0_res/flags stable, req0_ready=req1_ready=0, busy=1; completes on the 6th cycle.
REQ-037 req0 op=011 with CHECK_OP=1 -> res=0, flags=1000; then assert rst_n=0 during the next EXEC -> no rsp after release.
